// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code constants and conversion helper
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  // Prefix-XOR form; narrower codes zero-extend, which leaves their low bits exact.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b = g;
    for (int s = 1; s < GRAY_W_MAX; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// rtl/gray2bin_comb.sv - combinational Gray-to-binary XOR chain
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  logic acc;

  // Running XOR from the MSB down: b[i] is the parity of g[WIDTH-1:i].
  always_comb begin
    b   = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
  end

endmodule

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - registered Gray-to-binary converter with valid strobe
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] g,
  output logic             out_valid,
  output logic [WIDTH-1:0] b
);

  logic [WIDTH-1:0] b_next;

  gray2bin_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .g(g),
    .b(b_next)
  );

  // b keeps its last result while idle; out_valid marks only fresh words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        b <= b_next;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_bin.sv
// tb/tb_gray_to_bin.sv - self-checking bench for gray_to_bin at WIDTH 4 and 8
module tb_gray_to_bin;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv4, ov4;
  logic [3:0] g4, b4;
  logic       iv8, ov8;
  logic [7:0] g8, b8;

  int checks   = 0;
  int failures = 0;
  int lut4[16];
  int lut8[256];
  logic [7:0] exp8;

  gray_to_bin #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .g(g4), .out_valid(ov4), .b(b4)
  );

  gray_to_bin #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .g(g8), .out_valid(ov8), .b(b8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reference: invert the forward map gray = bin ^ (bin >> 1).
    for (int n = 0; n < 16; n++) lut4[n ^ (n >> 1)] = n;
    for (int n = 0; n < 256; n++) lut8[n ^ (n >> 1)] = n;

    rst_n = 1'b0;
    iv4 = 1'b0; g4 = '0;
    iv8 = 1'b0; g8 = '0;
    #2;
    check("reset_b4", 32'(b4), 32'h0);
    check("reset_ov4", 32'(ov4), 32'h0);
    check("reset_b8", 32'(b8), 32'h0);
    check("reset_ov8", 32'(ov8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    iv4 = 1'b1; g4 = 4'hf;
    tick();
    check("pre_async_b4", 32'(b4), 32'(lut4[15]));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_b4", 32'(b4), 32'h0);
    check("async_ov4", 32'(ov4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      g4 = 4'(v); iv4 = 1'b1;
      tick();
      check("sweep_b4", 32'(b4), 32'(lut4[v]));
      check("sweep_ov4", 32'(ov4), 32'h1);
      if (v == 7)  check("spot_0111", 32'(b4), 32'h5);
      if (v == 8)  check("spot_1000", 32'(b4), 32'hf);
      if (v == 9)  check("spot_1001", 32'(b4), 32'he);
      if (v == 12) check("spot_1100", 32'(b4), 32'h8);
      if (v == 15) check("spot_1111", 32'(b4), 32'ha);
    end

    g4 = 4'b0011; iv4 = 1'b1;
    tick();
    check("hold_accept_b4", 32'(b4), 32'h2);
    iv4 = 1'b0; g4 = 4'b1110;
    tick();
    check("hold_b4", 32'(b4), 32'h2);
    check("hold_ov4", 32'(ov4), 32'h0);
    tick();
    check("hold2_b4", 32'(b4), 32'h2);

    g4 = 4'b0110; iv4 = 1'b1;
    tick();
    check("mid_accept_b4", 32'(b4), 32'h4);
    check("mid_accept_ov4", 32'(ov4), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_b4", 32'(b4), 32'h0);
    check("mid_reset_ov4", 32'(ov4), 32'h0);
    g4 = 4'b0101;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_b4", 32'(b4), 32'h6);
    check("post_reset_ov4", 32'(ov4), 32'h1);
    iv4 = 1'b0;

    g8 = 8'h80; iv8 = 1'b1;
    tick();
    check("w8_80", 32'(b8), 32'hff);
    g8 = 8'h55;
    tick();
    check("w8_55", 32'(b8), 32'h66);
    check("w8_ov", 32'(ov8), 32'h1);
    exp8 = 8'h66;

    for (int k = 0; k < 1000; k++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      g8  = 8'($urandom);
      tick();
      if (iv8) exp8 = 8'(lut8[g8]);
      check("rand_b8", 32'(b8), 32'(exp8));
      check("rand_ov8", 32'(ov8), 32'(iv8));
    end
    check("idle_ov4", 32'(ov4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
